// File: rtl/restore_mean_value.sv
// restore_mean_value
// Re-inserts a DC level into a zero-mean signed 32-bit sample stream and
// emits 16-bit unsigned offset-binary codes for the DAC path. The applied
// mean slews toward a loadable target by at most STEP per processed sample,
// and the sum is saturated to 0..65535 with a sticky clip flag.
module restore_mean_value #(
  parameter int unsigned MEAN_INIT = 32768,
  parameter int unsigned STEP      = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        CE,
  input  logic [15:0] mean_in,
  input  logic        mean_load,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        clipped
);

  localparam logic [15:0] MEAN_RST = 16'(MEAN_INIT);
  localparam logic [16:0] STEP_W   = 17'(STEP);

  typedef enum logic [1:0] {
    init,
    esperar,
    calc,
    salida
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] sample_reg;
  logic [15:0] mean_cur;
  logic [15:0] mean_target;

  logic signed [32:0] sum;
  logic signed [16:0] diff;
  logic [16:0]        diff_abs;
  logic [15:0]        mean_next;
  logic [15:0]        sat_val;
  logic               sat_hit;

  // Saturating sum of the held sample and the pre-slew mean, plus the next
  // slewed mean value; both are consumed only on the calc edge.
  // NOTE: every signal driven here gets a default first so no path can leave
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    sum       = $signed({sample_reg[31], sample_reg}) + $signed({17'd0, mean_cur});
    sat_val   = sum[15:0];
    sat_hit   = 1'b0;
    if (sum[32]) begin
      sat_val = 16'd0;
      sat_hit = 1'b1;
    end else if (sum[31:16] != 16'd0) begin
      sat_val = 16'hffff;
      sat_hit = 1'b1;
    end

    diff      = $signed({1'b0, mean_target}) - $signed({1'b0, mean_cur});
    diff_abs  = diff[16] ? $unsigned(-diff) : $unsigned(diff);
    mean_next = mean_target;
    // A move of exactly STEP is only taken when |diff| > STEP, so the mean can
    // never cross the target and stays inside 0..65535.
    if ((STEP != 0) && (diff_abs > STEP_W)) begin
      if (diff[16]) mean_next = mean_cur - STEP_W[15:0];
      else          mean_next = mean_cur + STEP_W[15:0];
    end
  end

  // Next-state logic: CE is only honoured while waiting; calc and salida run
  // unconditionally, giving one sample per three clocks at most.
  always_comb begin
    state_next = state;
    case (state)
      init:    state_next = esperar;
      esperar: if (CE) state_next = calc;
      calc:    state_next = salida;
      salida:  state_next = esperar;
      default: state_next = init;
    endcase
  end

  // State register; reset is synchronous and wins over everything else.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock) begin
    if (reset) state <= init;
    else       state <= state_next;
  end

  // Datapath and output registers, updated according to the current state.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_out    <= 16'd0;
      data_valid  <= 1'b0;
      clipped     <= 1'b0;
      mean_cur    <= MEAN_RST;
      mean_target <= MEAN_RST;
      sample_reg  <= 32'd0;
    end else begin
      // A load coinciding with calc lands after the slew has used the old
      // target, so it only affects the following sample.
      if (mean_load) mean_target <= mean_in;
      case (state)
        init: begin
          data_out   <= 16'd0;
          data_valid <= 1'b0;
        end
        esperar: begin
          data_valid <= 1'b0;
          if (CE) sample_reg <= data_in;
        end
        calc: begin
          data_out <= sat_val;
          if (sat_hit) clipped <= 1'b1;
          mean_cur <= mean_next;
        end
        salida: begin
          data_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restore_mean_value.sv
// Self-checking bench for restore_mean_value. Two instances share stimulus:
// one slewing with STEP=16, one with STEP=0 (immediate mean jumps). A
// transaction-level model tracks the mean, target and clip flag per instance.
module tb_restore_mean_value;

  localparam int MEAN_INIT = 32768;
  localparam int STEP      = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] data_in;
  logic        CE;
  logic [15:0] mean_in;
  logic        mean_load;
  logic [15:0] data_out,   data_out0;
  logic        data_valid, data_valid0;
  logic        clipped,    clipped0;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: index 0 = STEP instance, index 1 = STEP=0 instance
  int m_cur [2];
  int m_tgt;
  bit m_clip[2];

  always #5 clock = ~clock;

  restore_mean_value #(.MEAN_INIT(MEAN_INIT), .STEP(STEP)) u_dut (
    .clock(clock), .reset(reset), .data_in(data_in), .CE(CE),
    .mean_in(mean_in), .mean_load(mean_load),
    .data_out(data_out), .data_valid(data_valid), .clipped(clipped)
  );

  restore_mean_value #(.MEAN_INIT(MEAN_INIT), .STEP(0)) u_dut0 (
    .clock(clock), .reset(reset), .data_in(data_in), .CE(CE),
    .mean_in(mean_in), .mean_load(mean_load),
    .data_out(data_out0), .data_valid(data_valid0), .clipped(clipped0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_cur[0]  = MEAN_INIT;
    m_cur[1]  = MEAN_INIT;
    m_tgt     = MEAN_INIT;
    m_clip[0] = 1'b0;
    m_clip[1] = 1'b0;
  endfunction

  // Output code for one sample, then move the mean toward the target.
  function automatic int model_calc(input int idx, input int step, input longint x);
    longint s;
    int     d;
    int     r;
    s = x + longint'(m_cur[idx]);
    if (s < 0) begin
      r = 0;
      m_clip[idx] = 1'b1;
    end else if (s > 65535) begin
      r = 65535;
      m_clip[idx] = 1'b1;
    end else begin
      r = int'(s);
    end
    d = m_tgt - m_cur[idx];
    if (step == 0 || (d <= step && d >= -step)) m_cur[idx] = m_tgt;
    else if (d > 0)                             m_cur[idx] = m_cur[idx] + step;
    else                                        m_cur[idx] = m_cur[idx] - step;
    return r;
  endfunction

  task automatic load_mean(input int v);
    mean_in   = 16'(v);
    mean_load = 1'b1;
    @(posedge clock); #1;
    mean_load = 1'b0;
    m_tgt     = v;
  endtask

  // One sample: accept on the next edge, check calc and data_valid edges.
  // Returns right after the data_valid edge so the next call lands on the
  // earliest possible accept edge.
  task automatic send_sample(input string tag, input int x, input bit load_at_calc, input int load_val);
    int e0;
    int e1;
    data_in = x;
    CE      = 1'b1;
    @(posedge clock); #1;
    CE      = 1'b0;
    data_in = $urandom;
    check({tag, "_dv_acc"},  32'(data_valid),  0);
    check({tag, "_dv0_acc"}, 32'(data_valid0), 0);
    if (load_at_calc) begin
      mean_in   = 16'(load_val);
      mean_load = 1'b1;
    end
    @(posedge clock); #1;
    mean_load = 1'b0;
    e0 = model_calc(0, STEP, longint'(x));
    e1 = model_calc(1, 0,    longint'(x));
    if (load_at_calc) m_tgt = load_val;
    check({tag, "_out"},    32'(data_out),   32'(e0));
    check({tag, "_out0"},   32'(data_out0),  32'(e1));
    check({tag, "_clip"},   32'(clipped),    32'(m_clip[0]));
    check({tag, "_clip0"},  32'(clipped0),   32'(m_clip[1]));
    check({tag, "_dv_calc"}, 32'(data_valid), 0);
    @(posedge clock); #1;
    check({tag, "_dv"},      32'(data_valid),  1);
    check({tag, "_dv0"},     32'(data_valid0), 1);
    check({tag, "_out_hold"}, 32'(data_out),   32'(e0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int pulses;
    int e0;
    int e1;

    // reset, with a competing mean_load that must be ignored
    reset     = 1'b1;
    CE        = 1'b0;
    data_in   = 32'd0;
    mean_in   = 16'd1234;
    mean_load = 1'b1;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("rst_out",  32'(data_out),   0);
    check("rst_dv",   32'(data_valid), 0);
    check("rst_clip", 32'(clipped),    0);
    check("rst_out0", 32'(data_out0),  0);
    reset     = 1'b0;
    mean_load = 1'b0;
    @(posedge clock); #1;
    check("init_dv", 32'(data_valid), 0);

    // offset: mean 32768, -100 -> 32668; second sample proves target unchanged
    send_sample("offset", -100, 1'b0, 0);
    send_sample("offset2", 7, 1'b0, 0);

    // saturation both ways, clip flag sticky
    send_sample("sat_hi",  40000,  1'b0, 0);
    send_sample("sat_lo",  -40000, 1'b0, 0);
    send_sample("sat_mid", 0,      1'b0, 0);

    // slew up by STEP and then back down
    load_mean(32800);
    repeat (4) send_sample("slew_up", 0, 1'b0, 0);
    load_mean(32790);
    repeat (2) send_sample("slew_dn", 0, 1'b0, 0);

    // load on the calc edge: this sample uses old mean and old target
    send_sample("coll0", 5, 1'b1, 33000);
    send_sample("coll1", 0, 1'b0, 0);
    send_sample("coll2", 0, 1'b0, 0);

    // continuous CE for 12 clocks with incrementing data
    base   = int'($urandom_range(0, 1000));
    pulses = 0;
    CE     = 1'b1;
    for (int i = 0; i < 12; i++) begin
      data_in = 32'(base + i);
      @(posedge clock); #1;
      if (i % 3 == 1) begin
        e0 = model_calc(0, STEP, longint'(base + i - 1));
        e1 = model_calc(1, 0,    longint'(base + i - 1));
        check("cont_out",  32'(data_out),  32'(e0));
        check("cont_out0", 32'(data_out0), 32'(e1));
      end
      if (data_valid) pulses++;
      check("cont_dv", 32'(data_valid), 32'(i % 3 == 2));
    end
    CE = 1'b0;
    check("cont_pulses", 32'(pulses), 4);

    // move the mean away from MEAN_INIT, then reset during calc
    load_mean(20000);
    send_sample("pre_rst", 0, 1'b0, 0);
    data_in = 32'd123;
    CE      = 1'b1;
    @(posedge clock); #1;
    CE      = 1'b0;
    reset   = 1'b1;
    @(posedge clock); #1;
    reset   = 1'b0;
    model_reset();
    check("mrst_out",  32'(data_out),   0);
    check("mrst_clip", 32'(clipped),    0);
    check("mrst_dv",   32'(data_valid), 0);
    @(posedge clock); #1;
    check("mrst_dv_init", 32'(data_valid), 0);
    check("mrst_out_init", 32'(data_out),  0);
    send_sample("post_rst0", 0, 1'b0, 0);
    send_sample("post_rst1", 0, 1'b0, 0);

    // randomized traffic with random target loads
    for (int n = 0; n < 40; n++) begin
      int x;
      int sel;
      bit lac;
      int lv;
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) lv = m_cur[0] - 60 + int'($urandom_range(0, 120));
        else                           lv = int'($urandom_range(0, 65535));
        if (lv < 0)     lv = 0;
        if (lv > 65535) lv = 65535;
        load_mean(lv);
      end
      sel = int'($urandom_range(0, 2));
      if (sel == 0)      x = int'($urandom_range(0, 400)) - 200;
      else if (sel == 1) x = int'($urandom_range(0, 140000)) - 70000;
      else               x = int'($urandom);
      lac = ($urandom_range(0, 5) == 0);
      lv  = int'($urandom_range(0, 65535));
      send_sample("rand", x, lac, lv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
